// File: rtl/draw_sched_pkg.sv
// Shared types for the draw_sched scheduler: box record, sequencer states and
// coordinate field widths.
package draw_pkg;

    localparam int XW = 11;
    localparam int YW = 11;
    localparam int SW = 8;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [SW-1:0] w;
        logic [SW-1:0] h;
    } box_t;

    localparam int BOX_W = $bits(box_t);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_UPDATE = 3'd4
    } state_t;

endpackage

// File: rtl/draw_sched_if.sv
// Requester streams and engine strobes of draw_sched. master = requesters and
// draw engine side, slave = the scheduler.
interface draw_sched_if
    import draw_pkg::*;
#(
    parameter int NREQ = 2
);
    // Requester i hands over req_box slice i on any rising clk edge where
    // req_valid[i] & req_ready[i]; valid may rise freely, ready never waits on
    // anything but valid, the FIFO level and the round-robin pointer.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*BOX_W-1:0] req_box;

    logic                  add_sq;
    logic                  clear;
    logic                  update;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [SW-1:0]         w;
    logic [SW-1:0]         h;

    modport master (
        output req_valid, req_box,
        input  req_ready, add_sq, clear, update, x, y, w, h
    );

    modport slave (
        input  req_valid, req_box,
        output req_ready, add_sq, clear, update, x, y, w, h
    );

endinterface

// File: rtl/draw_box_fifo.sv
// Single-clock box FIFO with a first-word-fall-through head; push is ignored
// when full and pop when empty.
module draw_box_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  box_t                   push_box,
    input  logic                   pop,
    output box_t                   head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    box_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_box;
    end

endmodule

// File: rtl/draw_sched.sv
// Round-robin box collector and per-frame clear/add_sq/update sequencer for the
// draw overlay engine. Optional DRAW_SCHED_HOLD_EN: skip empty frames entirely.
module draw_sched
    import draw_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DEPTH   = 16,
    parameter int GAP_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    draw_sched_if.slave   bus,
    output logic          busy,
    output logic          overrun,
    output logic [15:0]   drop_cnt,
    output state_t        o_dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYC + 1);

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_vsync_q;
    logic            w_vs_rise;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   w_win_idx;
    logic            w_win_vld;
    logic            w_accept;
    logic [NREQ-1:0] w_ready;
    box_t            w_win_box;
    box_t            w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   r_n_left;
    logic [GW-1:0]   r_gap_cnt;
    logic            w_gap_done;
    box_t            r_box_out;
    logic            r_overrun;
    logic [15:0]     r_drop_cnt;

    // Lowest-index valid at or above the pointer wins; otherwise the lowest
    // valid below it (second loop overrides the first).
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i < int'(r_rr_ptr))) begin
                w_win_vld = 1'b1;
                w_win_idx = PW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i >= int'(r_rr_ptr))) begin
                w_win_vld = 1'b1;
                w_win_idx = PW'(i);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = !w_full && w_win_vld && (w_win_idx == PW'(i));
        end
    end

    assign bus.req_ready = w_ready;
    assign w_accept      = w_win_vld && !w_full;
    assign w_win_box     = box_t'(bus.req_box[int'(w_win_idx)*BOX_W +: BOX_W]);

    draw_box_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_accept),
        .push_box (w_win_box),
        .pop      (w_pop),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    assign w_vs_rise  = vsync && !r_vsync_q;
    assign w_pop      = (r_state == ST_ISSUE) && !w_empty;
    assign w_gap_done = (r_gap_cnt == GW'(GAP_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise) begin
`ifdef DRAW_SCHED_HOLD_EN
                    if (w_count != '0) w_state_nx = ST_CLEAR;
`else
                    w_state_nx = ST_CLEAR;
`endif
                end
            end
            ST_CLEAR:  w_state_nx = (r_n_left != '0) ? ST_ISSUE : ST_UPDATE;
            ST_ISSUE:  w_state_nx = ST_GAP;
            ST_GAP: begin
                if (w_gap_done) w_state_nx = (r_n_left != '0) ? ST_ISSUE : ST_UPDATE;
            end
            ST_UPDATE: w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // The box is latched on entry to ISSUE from the FIFO head and popped at
    // the end of ISSUE, so x/y/w/h are valid exactly while add_sq is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_q  <= 1'b0;
            r_rr_ptr   <= '0;
            r_n_left   <= '0;
            r_gap_cnt  <= '0;
            r_box_out  <= '0;
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_vsync_q <= vsync;
            if (w_accept) begin
                r_rr_ptr <= (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
            end
            if ((r_state == ST_IDLE) && (w_state_nx == ST_CLEAR)) begin
                r_n_left <= w_count;
            end else if (w_pop) begin
                r_n_left <= r_n_left - CW'(1);
            end
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GW'(1) : '0;
            if (w_state_nx == ST_ISSUE) r_box_out <= w_head;
            if (w_vs_rise && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            if (w_full && (|bus.req_valid) && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign bus.add_sq  = (r_state == ST_ISSUE);
    assign bus.clear   = (r_state == ST_CLEAR);
    assign bus.update  = (r_state == ST_UPDATE);
    assign bus.x       = r_box_out.x;
    assign bus.y       = r_box_out.y;
    assign bus.w       = r_box_out.w;
    assign bus.h       = r_box_out.h;
    assign busy        = (r_state != ST_IDLE);
    assign overrun     = r_overrun;
    assign drop_cnt    = r_drop_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_draw_sched.sv
// Bench for draw_sched: directed frame scenarios plus random traffic, checked
// cycle by cycle against a schedule-level model of the scheduler.
module tb_draw_sched;
  import draw_pkg::*;

  localparam int NR = 2;
  localparam int D  = 16;
  localparam int G  = 4;
  localparam int BW = BOX_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        busy;
  logic        overrun;
  logic [15:0] drop_cnt;
  state_t      dbg_state;

  draw_sched_if #(.NREQ(NR)) dif ();

  draw_sched #(
    .NREQ    (NR),
    .DEPTH   (D),
    .GAP_CYC (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .bus         (dif.slave),
    .busy        (busy),
    .overrun     (overrun),
    .drop_cnt    (drop_cnt),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: boxes held, frame schedule from the latency rule, counters.
  logic [BW-1:0] exp_q[$];
  int            rr;
  bit            vs_prev;
  bit            m_active;
  int            m_n0;
  int            m_n;
  bit            m_over;
  int            m_drop;
  logic [BW-1:0] m_last;
  int            cyc;
  bit            chk_en;

  function automatic logic [BW-1:0] rand_box();
    logic [10:0] rx;
    logic [10:0] ry;
    logic [7:0]  rw;
    logic [7:0]  rh;
    rx = 11'($urandom_range(0, 1919));
    ry = 11'($urandom_range(0, 1079));
    rw = 8'($urandom_range(8, 255));
    rh = 8'($urandom_range(8, 255));
    return {rx, ry, rw, rh};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    rr       = 0;
    vs_prev  = 1'b0;
    m_active = 1'b0;
    m_n0     = 0;
    m_n      = 0;
    m_over   = 1'b0;
    m_drop   = 0;
    m_last   = '0;
  endtask

  task automatic start_frame();
    m_active = 1'b1;
    m_n0     = cyc;
    m_n      = exp_q.size();
  endtask

  task automatic step();
    int            rel;
    int            last;
    int            win;
    bit            e_clear;
    bit            e_add;
    bit            e_upd;
    bit            e_busy;
    bit            vs_rise;
    bit            was_full;
    logic [NR-1:0] e_ready;
    logic [BW-1:0] obs_box;
    logic [4:0]    obs_st;
    logic [4:0]    exp_st;
    @(negedge clk);
    rel     = cyc - m_n0;
    last    = 2 + m_n * (G + 1);
    e_busy  = m_active;
    e_clear = m_active && (rel == 1);
    e_add   = m_active && (rel >= 2) && (rel < last) && (((rel - 2) % (G + 1)) == 0);
    e_upd   = m_active && (rel == last);
    if (e_add && exp_q.size() > 0) m_last = exp_q[0];
    win = -1;
    for (int k = 0; k < NR; k++) begin
      if (win < 0 && dif.req_valid[(rr + k) % NR]) win = (rr + k) % NR;
    end
    was_full = (exp_q.size() >= D);
    e_ready  = '0;
    if (win >= 0 && !was_full) e_ready[win] = 1'b1;
    vs_rise = vsync && !vs_prev;
    if (chk_en) begin
      obs_st = {dif.add_sq, dif.clear, dif.update, busy, overrun};
      exp_st = {e_add, e_clear, e_upd, e_busy, m_over};
      checks++;
      assert (obs_st === exp_st) else begin
        failures++;
        $error("FAIL strobes cyc=%0d observed={add,clr,upd,busy,ovr}=%b expected=%b", cyc, obs_st, exp_st);
      end
      checks++;
      assert (dif.req_ready === e_ready) else begin
        failures++;
        $error("FAIL req_ready cyc=%0d observed=%b expected=%b", cyc, dif.req_ready, e_ready);
      end
      obs_box = {dif.x, dif.y, dif.w, dif.h};
      checks++;
      assert (obs_box === m_last) else begin
        failures++;
        $error("FAIL box_out cyc=%0d observed=%h expected=%h", cyc, obs_box, m_last);
      end
      checks++;
      assert (drop_cnt === 16'(m_drop)) else begin
        failures++;
        $error("FAIL drop_cnt cyc=%0d observed=%0d expected=%0d", cyc, drop_cnt, m_drop);
      end
    end
    if (rst) begin
      model_reset();
      chk_en = 1'b1;
    end else begin
      if (vs_rise) begin
        if (e_busy) begin
          m_over = 1'b1;
        end else begin
`ifdef DRAW_SCHED_HOLD_EN
          if (exp_q.size() > 0) start_frame();
`else
          start_frame();
`endif
        end
      end
      if (e_upd) m_active = 1'b0;
      if (e_add && exp_q.size() > 0) void'(exp_q.pop_front());
      if (was_full && (|dif.req_valid) && m_drop < 65535) m_drop++;
      if (win >= 0 && !was_full) begin
        exp_q.push_back(dif.req_box[win*BW +: BW]);
        rr = (win + 1) % NR;
      end
      vs_prev = vsync;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
  endtask

  logic [BW-1:0] dir [3];
  bit            reached;

  initial begin
    rst           = 1'b1;
    vsync         = 1'b0;
    dif.req_valid = '0;
    dif.req_box   = '0;
    chk_en        = 1'b0;
    cyc           = 0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    // Three known boxes from requester 0, then one frame.
    dir[0] = {11'd100,  11'd200,  8'd48, 8'd48};
    dir[1] = {11'd300,  11'd50,   8'd48, 8'd48};
    dir[2] = {11'd1800, 11'd1000, 8'd48, 8'd48};
    for (int i = 0; i < 3; i++) begin
      dif.req_valid        = 2'b01;
      dif.req_box[BW-1:0]  = dir[i];
      step();
    end
    dif.req_valid = '0;
    step();
    vs_pulse();
    repeat (20) step();

    // Both requesters contend until the FIFO fills and stalls accumulate.
    dif.req_valid = 2'b11;
    repeat (24) begin
      dif.req_box = {rand_box(), rand_box()};
      step();
    end
    dif.req_valid = '0;
    step();
    vs_pulse();
    repeat (90) step();

    // Push in the vs_rise cycle: this frame is empty, the next one carries it.
    dif.req_valid            = 2'b10;
    dif.req_box[2*BW-1:BW]   = rand_box();
    vsync                    = 1'b1;
    step();
    dif.req_valid = '0;
    vsync         = 1'b0;
    repeat (6) step();
    vs_pulse();
    repeat (10) step();

    // Second frame edge while in GAP.
    dif.req_valid = 2'b01;
    repeat (2) begin
      dif.req_box[BW-1:0] = rand_box();
      step();
    end
    dif.req_valid = '0;
    vs_pulse();
    repeat (3) step();
    vs_pulse();
    repeat (16) step();

    // Reset landing on the second add_sq of a frame.
    dif.req_valid = 2'b01;
    repeat (3) begin
      dif.req_box[BW-1:0] = rand_box();
      step();
    end
    dif.req_valid = '0;
    vs_pulse();
    reached = 1'b0;
    for (int t = 0; t < 60 && !reached; t++) begin
      if (m_active && (cyc - m_n0) == 2 + (G + 1)) reached = 1'b1;
      else step();
    end
    checks++;
    assert (reached) else begin
      failures++;
      $error("FAIL second_add_timeout observed=%0d expected=%0d", reached, 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    vs_pulse();
    repeat (6) step();

    // Random traffic and frame edges.
    repeat (600) begin
      dif.req_valid = 2'($urandom_range(0, 3));
      dif.req_box   = {rand_box(), rand_box()};
      if ($urandom_range(0, 39) == 0) vsync = ~vsync;
      step();
    end
    dif.req_valid = '0;
    vsync         = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
